// File: rtl/song_seq_pkg.sv
// Shared types and constants for the song sequencer.
package song_seq_pkg;

  typedef enum logic [1:0] {
    SEQ        = 2'd0,
    LOOP_ALL   = 2'd1,
    REPEAT_ONE = 2'd2,
    SHUFFLE    = 2'd3
  } play_mode_e;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Song index width: max(1, clog2(n))
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/song_btn_repeat.sv
// Button step generator: first step on press, auto-repeat after a hold delay,
// re-armed on release. step_valid/step_dir are combinational so the index
// updates on the same edge that samples the button.
module song_btn_repeat
  import song_seq_pkg::*;
#(
  parameter int unsigned HOLD_DELAY    = 1000000,
  parameter int unsigned REPEAT_PERIOD = 250000
) (
  input  logic       MP3_SCLK,
  input  logic       RESET,
  input  logic [1:0] req,         // {next, last}
  output logic       step_valid,
  output logic       step_dir     // 1: +1, 0: -1
);

  localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_next, go_last, active, idle;

  assign go_next = (req == 2'b10);
  assign go_last = (req == 2'b01);
  assign active  = go_next | go_last;
  assign idle    = (req == 2'b00);

  // State and counter registers
  always_ff @(posedge MP3_SCLK) begin
    if (RESET) begin
      state_q <= ARMED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and step decode; both buttons held freezes state and counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_valid = 1'b0;
    step_dir   = go_next;
    case (state_q)
      ARMED: begin
        if (active) begin
          step_valid = 1'b1;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (idle) begin
          cnt_d   = '0;
          state_d = ARMED;
        end else if (active) begin
          if (cnt_q == HOLD_LAST) begin
            step_valid = 1'b1;
            cnt_d      = '0;
            state_d    = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      REPEAT: begin
        if (idle) begin
          cnt_d   = '0;
          state_d = ARMED;
        end else if (active) begin
          if (cnt_q == REP_LAST) begin
            step_valid = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ARMED;
      end
    endcase
  end

endmodule

// File: rtl/song_sequencer.sv
// Song index / play-mode controller for the MP3 path.
// Optional shuffle mode: define SONG_SEQUENCER_SHUFFLE_EN.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int unsigned SONG_NUM      = 3,
  parameter int unsigned HOLD_DELAY    = 1000000,
  parameter int unsigned REPEAT_PERIOD = 250000
) (
  input  logic                              MP3_SCLK,
  input  logic                              RESET,
  input  logic                              MP3_LASTSONG,
  input  logic                              MP3_NEXTSONG,
  input  logic                              MP3_MODE,
  input  logic                              MP3_SONG_END,
  output logic [idx_width(SONG_NUM)-1:0]    SongNow,
  output logic [1:0]                        PlayMode,
  output logic                              SongChanged,
  output logic                              Stopped
);

  localparam int unsigned SONG_W = idx_width(SONG_NUM);
  localparam int unsigned SUM_W  = SONG_W + 1;
  localparam logic [SUM_W-1:0] LAST_IDX = SUM_W'(SONG_NUM - 1);
  localparam logic [SUM_W-1:0] NUM_W    = SUM_W'(SONG_NUM);

`ifdef SONG_SEQUENCER_SHUFFLE_EN
  localparam logic [1:0] MODE_LAST = 2'd3;
`else
  localparam logic [1:0] MODE_LAST = 2'd2;
`endif

  logic [SONG_W-1:0] song_q;
  logic [SUM_W-1:0]  song_d;
  play_mode_e        mode_q, mode_d;
  logic              changed_q, changed_d;
  logic              stopped_q, stopped_d;
  logic              mode_in_q;
  logic              mode_edge;
  logic              step_valid, step_dir;
  logic [SUM_W-1:0]  cur_w, inc_w, dec_w, shuf_w;

  song_btn_repeat #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn (
    .MP3_SCLK   (MP3_SCLK),
    .RESET      (RESET),
    .req        ({MP3_NEXTSONG, MP3_LASTSONG}),
    .step_valid (step_valid),
    .step_dir   (step_dir)
  );

  assign mode_edge = MP3_MODE & ~mode_in_q;

  // Wrapping neighbours of the current index, computed one bit wider
  assign cur_w = SUM_W'(song_q);
  assign inc_w = (cur_w == LAST_IDX) ? '0 : cur_w + SUM_W'(1);
  assign dec_w = (cur_w == '0) ? LAST_IDX : cur_w - SUM_W'(1);

`ifdef SONG_SEQUENCER_SHUFFLE_EN
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_off;
  logic [SUM_W-1:0] shuf_sum;

  // Free-running pseudo-random source, reseeded on reset
  always_ff @(posedge MP3_SCLK) begin
    if (RESET) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Offset in 1..SONG_NUM-1 from the current song, so it never repeats
  assign lfsr_off = lfsr_q % 16'(SONG_NUM - 1);
  assign shuf_sum = cur_w + SUM_W'(1) + SUM_W'(lfsr_off);
  assign shuf_w   = (shuf_sum >= NUM_W) ? shuf_sum - NUM_W : shuf_sum;
`else
  // Without shuffle, mode 3 is unreachable and behaves like LOOP_ALL
  assign shuf_w = inc_w;
`endif

  // Output and control registers
  always_ff @(posedge MP3_SCLK) begin
    if (RESET) begin
      song_q    <= '0;
      mode_q    <= SEQ;
      changed_q <= 1'b0;
      stopped_q <= 1'b0;
      mode_in_q <= 1'b0;
    end else begin
      song_q    <= SONG_W'(song_d);
      mode_q    <= mode_d;
      changed_q <= changed_d;
      stopped_q <= stopped_d;
      mode_in_q <= MP3_MODE;
    end
  end

  // Event arbitration: manual step beats song end; mode edge applies alongside
  always_comb begin
    song_d    = cur_w;
    mode_d    = mode_q;
    changed_d = 1'b0;
    stopped_d = stopped_q;
    if (step_valid) begin
      if (step_dir) song_d = (mode_q == SHUFFLE) ? shuf_w : inc_w;
      else          song_d = dec_w;
      changed_d = 1'b1;
      stopped_d = 1'b0;
    end else if (MP3_SONG_END && !stopped_q) begin
      case (mode_q)
        SEQ: begin
          if (cur_w == LAST_IDX) begin
            stopped_d = 1'b1;
          end else begin
            song_d    = inc_w;
            changed_d = 1'b1;
          end
        end
        LOOP_ALL: begin
          song_d    = inc_w;
          changed_d = 1'b1;
        end
        REPEAT_ONE: begin
          changed_d = 1'b1;
        end
        default: begin
          song_d    = shuf_w;
          changed_d = 1'b1;
        end
      endcase
    end
    if (mode_edge) begin
      mode_d    = (mode_q >= MODE_LAST) ? SEQ : play_mode_e'(mode_q + 2'd1);
      stopped_d = 1'b0;
    end
  end

  assign SongNow     = song_q;
  assign PlayMode    = mode_q;
  assign SongChanged = changed_q;
  assign Stopped     = stopped_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: directed scenarios then random button,
// mode and song-end traffic, checked against a cycle-level behavioural model.
module tb_song_sequencer;

  localparam int N  = 5;
  localparam int HD = 8;
  localparam int RP = 4;
`ifdef SONG_SEQUENCER_SHUFFLE_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  logic       MP3_SCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       MP3_LASTSONG = 1'b0;
  logic       MP3_NEXTSONG = 1'b0;
  logic       MP3_MODE = 1'b0;
  logic       MP3_SONG_END = 1'b0;
  logic [2:0] SongNow;
  logic [1:0] PlayMode;
  logic       SongChanged;
  logic       Stopped;

  song_sequencer #(.SONG_NUM(N), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut (
    .MP3_SCLK     (MP3_SCLK),
    .RESET        (RESET),
    .MP3_LASTSONG (MP3_LASTSONG),
    .MP3_NEXTSONG (MP3_NEXTSONG),
    .MP3_MODE     (MP3_MODE),
    .MP3_SONG_END (MP3_SONG_END),
    .SongNow      (SongNow),
    .PlayMode     (PlayMode),
    .SongChanged  (SongChanged),
    .Stopped      (Stopped)
  );

  always #5 MP3_SCLK = ~MP3_SCLK;

  typedef struct {
    int song;
    int mode;
    int chg;
    int stop;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: t counts single-direction cycles since release
  int          m_song = 0, m_mode = 0, m_stop = 0, m_chg = 0, m_t = 0;
  bit          m_prev_mode = 0;
  bit [15:0]   m_lfsr = 16'hACE1;

  function automatic int shuffle_of(input int s, input bit [15:0] l);
    return (s + 1 + (int'(l) % (N - 1))) % N;
  endfunction

  task automatic model_step(input bit n, input bit l, input bit m, input bit e, input bit r);
    int  dir;
    bit  step;
    bit  fb;
    if (r) begin
      m_song = 0; m_mode = 0; m_stop = 0; m_chg = 0; m_t = 0;
      m_prev_mode = 0; m_lfsr = 16'hACE1;
      return;
    end
    dir  = (n && !l) ? 1 : ((l && !n) ? -1 : 0);
    step = 0;
    if (dir != 0) begin
      step = (m_t == 0) || (m_t == HD) || (m_t > HD && ((m_t - HD) % RP) == 0);
      m_t++;
    end else if (!(n && l)) begin
      m_t = 0;
    end
    m_chg = 0;
    if (step) begin
      if (dir > 0) m_song = (NMODES == 4 && m_mode == 3) ? shuffle_of(m_song, m_lfsr) : (m_song + 1) % N;
      else         m_song = (m_song + N - 1) % N;
      m_chg  = 1;
      m_stop = 0;
    end else if (e && !m_stop) begin
      case (m_mode)
        0: if (m_song == N - 1) m_stop = 1; else begin m_song++; m_chg = 1; end
        2: m_chg = 1;
        3: begin
          m_song = (NMODES == 4) ? shuffle_of(m_song, m_lfsr) : (m_song + 1) % N;
          m_chg  = 1;
        end
        default: begin m_song = (m_song + 1) % N; m_chg = 1; end
      endcase
    end
    if (m && !m_prev_mode) begin
      m_mode = (m_mode + 1) % NMODES;
      m_stop = 0;
    end
    m_prev_mode = m;
    fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  // Apply one cycle of inputs and queue the state expected after the next edge
  task automatic drive(input bit n, input bit l, input bit m, input bit e, input bit r);
    exp_t x;
    @(negedge MP3_SCLK);
    #1;
    MP3_NEXTSONG = n; MP3_LASTSONG = l; MP3_MODE = m; MP3_SONG_END = e; RESET = r;
    model_step(n, l, m, e, r);
    cyc++;
    x.song = m_song; x.mode = m_mode; x.chg = m_chg; x.stop = m_stop; x.cyc = cyc;
    q.push_back(x);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input int expv, input int c);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, c, act, expv);
    end
  endtask

  // Monitor: pops one expectation per edge and compares all outputs
  initial begin
    exp_t x;
    forever begin
      @(negedge MP3_SCLK);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("SongNow",     32'(SongNow),     x.song, x.cyc);
        check("PlayMode",    32'(PlayMode),    x.mode, x.cyc);
        check("SongChanged", 32'(SongChanged), x.chg,  x.cyc);
        check("Stopped",     32'(Stopped),     x.stop, x.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rn, rl, rm, re, rr;
    // Taps and re-press
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); idle(2);
    // Hold NEXT 20 cycles, then LAST wrap from 0
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1); drive(0, 1, 0, 0, 0); idle(2);
    // SEQ end at last song, repeated end, then NEXT clears Stopped
    drive(0, 0, 0, 1, 0); idle(1); drive(0, 0, 0, 1, 0); idle(1);
    drive(1, 0, 0, 0, 0); idle(2);
    // To song 2, REPEAT_ONE restart
    drive(1, 0, 0, 0, 0); idle(1); drive(1, 0, 0, 0, 0); idle(1);
    drive(0, 0, 1, 0, 0); idle(1); drive(0, 0, 1, 0, 0); idle(1);
    drive(0, 0, 0, 1, 0); idle(2);
    // LOOP_ALL wrap from 4
    drive(0, 0, 0, 0, 1); drive(0, 0, 1, 0, 0); idle(1);
    drive(0, 1, 0, 0, 0); idle(1); drive(0, 0, 0, 1, 0); idle(2);
    // Step beats song end; both buttons held
    drive(0, 0, 0, 0, 1); drive(1, 0, 0, 0, 0); idle(1);
    drive(1, 0, 0, 1, 0); idle(1);
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);
    idle(2);
    // Direction change while held, mode edge together with song end
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
    idle(1); drive(0, 0, 1, 1, 0); idle(2);
    // Reset mid-repeat, NEXT kept held through and after reset
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
    idle(2);
`ifdef SONG_SEQUENCER_SHUFFLE_EN
    // Shuffle on song end and NEXT
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); idle(1); end
    for (int i = 0; i < 50; i++) begin drive(0, 0, 0, 1, 0); idle(1); end
    for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 0, 0); idle(1); end
`endif
    // Random traffic
    rn = 0; rl = 0;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rn = ~rn;
      if ($urandom_range(9) == 0) rl = ~rl;
      rm = ($urandom_range(11) == 0);
      re = ($urandom_range(4) == 0);
      rr = ($urandom_range(399) == 0);
      drive(rn, rl, rm, re, rr);
    end
    idle(2);
    @(negedge MP3_SCLK);
    @(negedge MP3_SCLK);
    check("queue_drained", 32'(q.size()), 0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised next-generation song selector for the MP3 player path.
- Tracks the current song index and handles LAST/NEXT buttons with a cooldown, hold-to-auto-repeat and release re-arm.
- Adds play modes: sequential, loop-all and repeat-one, plus optional shuffle. Decoder end-of-song pulses advance the index.
- Sits between the button inputs and the mp3 decoder, and feeds SongNow and SongChanged to the decoder and the OLED display.

Parameters:
- SONG_NUM, 3, total songs; must be >= 2.
- HOLD_DELAY, 1000000, MP3_SCLK cycles a button must be held before auto-repeat starts.
- REPEAT_PERIOD, 250000, cycles between auto-repeat steps while the button is held.
- SONG_W, localparam = max(1, $clog2(SONG_NUM)), index width.

Ports:
- MP3_SCLK  in  1  sole clock; all logic updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MP3_LASTSONG  in  1  previous-song button, level.
- MP3_NEXTSONG  in  1  next-song button, level.
- MP3_MODE  in  1  play-mode button, level; acts once on its rising edge.
- MP3_SONG_END  in  1  one-cycle pulse from the decoder when a song finishes.
- SongNow  out  SONG_W  current song index.
- PlayMode  out  2  0 SEQ, 1 LOOP_ALL, 2 REPEAT_ONE, 3 SHUFFLE.
- SongChanged  out  1  one-cycle pulse: the decoder must (re)start SongNow.
- Stopped  out  1  high after SEQ finishes the last song.

Behaviour:
- Reset values: SongNow=0, PlayMode=0, SongChanged=0, Stopped=0. Button FSM goes to ARMED, counter=0, mode-edge register=0.
- While RESET is high, all other inputs are ignored. Reset mid-hold returns the FSM to ARMED.
- Response latency: outputs change on the same rising edge that samples the triggering input.
- Button direction is dir = NEXT & ~LAST -> +1, LAST & ~NEXT -> -1; both or neither -> none.
- Button FSM:
  - ARMED: if dir != none, take one step, clear the counter, go to HOLD.
  - HOLD: if dir == none, go to ARMED. Else the counter increments; at HOLD_DELAY-1, take a step, clear the counter, go to REPEAT.
  - REPEAT: if dir == none, go to ARMED. Else at REPEAT_PERIOD-1, take a step and clear the counter.
  - A direction change while held (NEXT -> LAST without release) does not step. It keeps counting and the next step uses the new direction.
  - Both buttons held: no step; state and counter hold their values.
- A step is a manual change:
  - SongNow goes to SongNow±1 with wrap: 0-1 -> SONG_NUM-1, SONG_NUM-1+1 -> 0.
  - SongChanged pulses for that cycle and Stopped clears.
  - In SHUFFLE, +1 uses the shuffle rule; -1 stays plain decrement.
- MP3_SONG_END handling by mode:
  - SEQ, not at the last song: increment SongNow and pulse SongChanged.
  - SEQ, at the last song: SongNow holds, Stopped=1, no pulse.
  - LOOP_ALL: wrapping increment and pulse.
  - REPEAT_ONE: SongNow unchanged, pulse SongChanged (restart).
  - SHUFFLE: shuffle rule and pulse.
  - SONG_END while Stopped=1 is ignored.
- Simultaneous events:
  - A manual step beats SONG_END in the same cycle; the SONG_END is dropped.
  - A MODE edge is applied in the same cycle as either event. The event uses the old mode.
- MODE rising edge: PlayMode cycles 0->1->2->0, or through 3 when SHUFFLE_EN is defined. Stopped clears; SongNow is unchanged; no pulse.
- Width rule: all index arithmetic is done in SONG_W+1 bits and the wrap is compared against SONG_NUM. Correct for non-power-of-two SONG_NUM.

Optional Feature:
- Macro: SONG_SEQUENCER_SHUFFLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - Shuffle rule: next = (SongNow + 1 + (lfsr % (SONG_NUM-1))) wrapped mod SONG_NUM, so it never repeats the current song.
  - The mode cycle includes 3.
- Undefined:
  - No LFSR logic is present and the mode cycle is 0-2.
  - PlayMode can never equal 3. If it does, treat it as LOOP_ALL.

Decomposition:
- Package song_seq_pkg: play-mode enum (SEQ, LOOP_ALL, REPEAT_ONE, SHUFFLE), button-FSM state enum (ARMED, HOLD, REPEAT), LFSR seed and tap constants.
- Sub-module song_btn_repeat: takes a 2-bit request plus the delay/period parameters and outputs step_valid and step_dir. It holds the button FSM and counter.
- The top level owns the index, mode, stop and LFSR logic.

Test Plan (SONG_NUM=5, HOLD_DELAY=8, REPEAT_PERIOD=4):
- Reset, then NEXT high for 1 cycle -> SongNow=1 and SongChanged pulses once. NEXT low 1 cycle then high again -> SongNow=2.
- NEXT held 20 cycles from SongNow=0 -> steps at cycles 0, 8, 12, 16 -> SongNow=4. LAST tap from 0 -> 4 (wrap).
- SEQ mode at SongNow=4 with SONG_END -> Stopped=1, SongNow=4, no pulse. A second SONG_END -> still no change. NEXT tap -> SongNow=0, Stopped=0.
- MODE tapped twice (REPEAT_ONE) at SongNow=2, then SONG_END -> SongNow=2 with a SongChanged pulse. LOOP_ALL at 4 with SONG_END -> SongNow=0.
- NEXT and SONG_END in the same cycle at SongNow=1 -> SongNow=2 (not 3). Both buttons held 10 cycles -> no change.
- RESET asserted mid-repeat at SongNow=3 -> SongNow=0, PlayMode=0. A held NEXT after reset steps immediately. With SHUFFLE_EN, 50 SONG_END events in SHUFFLE -> SongNow never equals its previous value and stays below 5.
